// File: rtl/line_cache_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_cache_ctrl_if : CPU-side and line-adaptor-side buses of line_cache_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
interface line_cache_ctrl_if;
   logic [31:0]  cpu_addr;
   logic         cpu_read;
   logic         cpu_write;
   logic [31:0]  cpu_wdata;
   logic [3:0]   cpu_byte_enable;
   logic [31:0]  cpu_rdata;
   logic         cpu_resp;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_resp;

   // The cache controller is the slave of the CPU and the master toward memory.
   modport slave (
      input  cpu_addr, cpu_read, cpu_write, cpu_wdata, cpu_byte_enable,
      output cpu_rdata, cpu_resp,
      output mem_address, mem_read, mem_write, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport master (
      output cpu_addr, cpu_read, cpu_write, cpu_wdata, cpu_byte_enable,
      input  cpu_rdata, cpu_resp,
      input  mem_address, mem_read, mem_write, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface
`default_nettype wire

// File: rtl/line_cache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_cache_ctrl : direct-mapped write-back/write-allocate line cache control
// Revision 1.0
// ---------------------------------------------------------------------------
module line_cache_ctrl #(
   parameter int NUM_SETS  = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                clk,
   input  logic                rst,
   line_cache_ctrl_if.slave    bus,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count
);
   localparam int INDEX_W = $clog2(NUM_SETS);
   localparam int TAG_W   = 27 - INDEX_W;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COMPARE   = 2'd1,
      S_WRITEBACK = 2'd2,
      S_ALLOCATE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [31:2]          addr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           be_q;
   logic                 write_q;
   logic [NUM_SETS-1:0]  valid_q, dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_SETS];
   logic [LINE_BITS-1:0] data_q [NUM_SETS];
   logic [31:0]          hit_q, miss_q;

   logic [INDEX_W-1:0]   idx;
   logic [TAG_W-1:0]     req_tag;
   logic [7:0]           word_bit;
   logic                 hit;
   logic [31:0]          cur_word, merged;

   logic                 accept, cnt_hit, cnt_miss, set_dirty, clr_dirty, fill;
   logic [31:0]          cpu_rdata, mem_address;
   logic                 cpu_resp, mem_read, mem_write;
   logic [LINE_BITS-1:0] mem_wdata;

   assign idx      = addr_q[5 +: INDEX_W];
   assign req_tag  = addr_q[31 -: TAG_W];
   assign word_bit = {addr_q[4:2], 5'b0};
   assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
   assign cur_word = data_q[idx][word_bit +: 32];

   always_comb begin
      merged = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      cnt_hit     = 1'b0;
      cnt_miss    = 1'b0;
      set_dirty   = 1'b0;
      clr_dirty   = 1'b0;
      fill        = 1'b0;
      cpu_resp    = 1'b0;
      cpu_rdata   = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_read || bus.cpu_write) begin
               accept  = 1'b1;
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               cpu_resp  = 1'b1;
               cnt_hit   = 1'b1;
               set_dirty = write_q;
               if (!write_q) cpu_rdata = cur_word;
               state_d   = S_IDLE;
            end else begin
               cnt_miss = 1'b1;
               state_d  = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            mem_write   = 1'b1;
            mem_address = {tag_q[idx], idx, 5'b0};
            mem_wdata   = data_q[idx];
            if (bus.mem_resp) begin
               clr_dirty = 1'b1;
               state_d   = S_ALLOCATE;
            end
         end
         S_ALLOCATE: begin
            mem_read    = 1'b1;
            mem_address = {req_tag, idx, 5'b0};
            if (bus.mem_resp) begin
               fill    = 1'b1;
               state_d = S_COMPARE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         if (cnt_hit)   hit_q  <= hit_q + 32'd1;
         if (cnt_miss)  miss_q <= miss_q + 32'd1;
         if (set_dirty) dirty_q[idx] <= 1'b1;
         if (clr_dirty) dirty_q[idx] <= 1'b0;
         if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
      end
   end

   // Request latches and line storage carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= bus.cpu_addr[31:2];
         wdata_q <= bus.cpu_wdata;
         be_q    <= bus.cpu_byte_enable;
         write_q <= bus.cpu_write;
      end
      if (set_dirty) data_q[idx][word_bit +: 32] <= merged;
      if (fill) begin
         data_q[idx] <= bus.mem_rdata;
         tag_q[idx]  <= req_tag;
      end
   end

   assign bus.cpu_rdata   = cpu_rdata;
   assign bus.cpu_resp    = cpu_resp;
   assign bus.mem_address = mem_address;
   assign bus.mem_read    = mem_read;
   assign bus.mem_write   = mem_write;
   assign bus.mem_wdata   = mem_wdata;
   assign hit_count       = hit_q;
   assign miss_count      = miss_q;
endmodule
`default_nettype wire

// File: tb/tb_line_cache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_line_cache_ctrl : directed vector bench for line_cache_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_line_cache_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] hit_count, miss_count;

   line_cache_ctrl_if bus ();

   line_cache_ctrl #(.NUM_SETS(16), .LINE_BITS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;
   int overlap = 0, order_err = 0, unstable = 0;

   typedef struct {
      logic         rd, wr;
      logic [31:0]  addr, wdata;
      logic [3:0]   be;
      logic [31:0]  exp_rdata;
      int           exp_lat, exp_nrd, exp_nwr;
      logic [31:0]  exp_rd_addr, exp_wb_addr;
      logic [255:0] exp_wb;
      logic [31:0]  exp_hit, exp_miss;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Memory image returned by the adaptor model for a given line address.
   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h1000_0000 + ((a ^ 32'h40) << 8) + 32'(i);
      return l;
   endfunction

   task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output int lat, output int nrd, output int nwr,
                        output logic [31:0] rd_addr, output logic [31:0] wb_addr,
                        output logic [255:0] wb_data);
      int   age;
      logic done;
      @(negedge clk);
      bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_addr = addr;
      bus.cpu_wdata = wdata; bus.cpu_byte_enable = be;
      age = 0; done = 1'b0; lat = 0; nrd = 0; nwr = 0;
      rdata = '0; rd_addr = '0; wb_addr = '0; wb_data = '0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         lat++;
         bus.mem_resp = 1'b0;
         if (bus.mem_read && bus.mem_write) overlap++;
         if (bus.cpu_resp) begin
            rdata = bus.cpu_rdata;
            done  = 1'b1;
         end else if (bus.mem_read || bus.mem_write) begin
            age++;
            if (age == 1) begin
               if (bus.mem_write) begin
                  nwr++; wb_addr = bus.mem_address; wb_data = bus.mem_wdata;
                  if (nrd != 0) order_err++;
               end else begin
                  nrd++; rd_addr = bus.mem_address;
               end
            end else if (bus.mem_address != (bus.mem_write ? wb_addr : rd_addr)) begin
               unstable++;
            end
            if (age == 2) begin
               bus.mem_resp  = 1'b1;
               bus.mem_rdata = line_of(bus.mem_address);
               age = 0;
            end
         end else begin
            age = 0;
         end
      end
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
      if (!done) chk("op_timeout", 256'd0, 256'd1);
   endtask

   initial begin
      logic [255:0] wb_a, wb_b, wbd;
      logic [31:0]  rdata, rda, wba;
      int           lat, nrd, nwr, pulses, consec, memseen;
      logic         prev_resp, seen;
      logic [31:0]  hit0;

      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0;
      bus.cpu_wdata = '0; bus.cpu_byte_enable = '0;
      bus.mem_rdata = '0; bus.mem_resp = 1'b0;

      wb_a = line_of(32'h40);  wb_a[63:32] = 32'h10AD_00EF;
      wb_b = line_of(32'h1E0); wb_b[95:64] = 32'h1234_5678;

      vecs[0] = '{1'b1,1'b0,32'h40, 32'h0,4'h0,32'h1000_0000,4,1,0,32'h40, 32'h0,  256'd0,32'd1, 32'd1};
      vecs[1] = '{1'b0,1'b1,32'h44, 32'hDEAD_BEEF,4'b0101,32'h0,1,0,0,32'h0,32'h0,256'd0,32'd2,32'd1};
      vecs[2] = '{1'b1,1'b0,32'h44, 32'h0,4'h0,32'h10AD_00EF,1,0,0,32'h0, 32'h0,  256'd0,32'd3, 32'd1};
      vecs[3] = '{1'b1,1'b0,32'h5C, 32'h0,4'h0,32'h1000_0007,1,0,0,32'h0, 32'h0,  256'd0,32'd4, 32'd1};
      vecs[4] = '{1'b1,1'b0,32'h240,32'h0,4'h0,32'h1002_0000,6,1,1,32'h240,32'h40, wb_a, 32'd5, 32'd2};
      vecs[5] = '{1'b1,1'b0,32'h440,32'h0,4'h0,32'h1004_0000,4,1,0,32'h440,32'h0,  256'd0,32'd6, 32'd3};
      vecs[6] = '{1'b1,1'b0,32'h1E8,32'h0,4'h0,32'h1001_A002,4,1,0,32'h1E0,32'h0,  256'd0,32'd7, 32'd4};
      vecs[7] = '{1'b1,1'b1,32'h1E8,32'h1234_5678,4'hF,32'h0,1,0,0,32'h0,32'h0,    256'd0,32'd8, 32'd4};
      vecs[8] = '{1'b1,1'b0,32'h3E0,32'h0,4'h0,32'h1003_A000,6,1,1,32'h3E0,32'h1E0,wb_b, 32'd9, 32'd5};
      vecs[9] = '{1'b1,1'b0,32'h1E8,32'h0,4'h0,32'h1001_A002,4,1,0,32'h1E0,32'h0,  256'd0,32'd10,32'd6};

      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("rst_cpu_resp",  256'(bus.cpu_resp),    256'd0);
      chk("rst_mem_read",  256'(bus.mem_read),    256'd0);
      chk("rst_mem_write", 256'(bus.mem_write),   256'd0);
      chk("rst_cpu_rdata", 256'(bus.cpu_rdata),   256'd0);
      chk("rst_mem_addr",  256'(bus.mem_address), 256'd0);
      chk("rst_mem_wdata", bus.mem_wdata,         256'd0);
      chk("rst_hits",      256'(hit_count),       256'd0);
      chk("rst_misses",    256'(miss_count),      256'd0);

      for (int v = 0; v < 10; v++) begin
         do_op(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be,
               rdata, lat, nrd, nwr, rda, wba, wbd);
         chk($sformatf("v%0d_latency", v), 256'(lat), 256'(vecs[v].exp_lat));
         chk($sformatf("v%0d_nread", v),   256'(nrd), 256'(vecs[v].exp_nrd));
         chk($sformatf("v%0d_nwrite", v),  256'(nwr), 256'(vecs[v].exp_nwr));
         if (vecs[v].rd && !vecs[v].wr) chk($sformatf("v%0d_rdata", v), 256'(rdata), 256'(vecs[v].exp_rdata));
         if (vecs[v].exp_nrd != 0) chk($sformatf("v%0d_rd_addr", v), 256'(rda), 256'(vecs[v].exp_rd_addr));
         if (vecs[v].exp_nwr != 0) begin
            chk($sformatf("v%0d_wb_addr", v), 256'(wba), 256'(vecs[v].exp_wb_addr));
            chk($sformatf("v%0d_wb_data", v), wbd,       vecs[v].exp_wb);
         end
         @(negedge clk);
         chk($sformatf("v%0d_hits", v),   256'(hit_count),  256'(vecs[v].exp_hit));
         chk($sformatf("v%0d_misses", v), 256'(miss_count), 256'(vecs[v].exp_miss));
      end

      // Dirty up set 2, then reset while the writeback waits for mem_resp.
      do_op(1'b0, 1'b1, 32'h440, 32'hCAFE_F00D, 4'hF, rdata, lat, nrd, nwr, rda, wba, wbd);
      chk("dirty_store_latency", 256'(lat), 256'd1);
      @(negedge clk);
      bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 32'h240;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.mem_write) seen = 1'b1;
      end
      chk("wb_started", 256'(seen), 256'd1);
      rst = 1'b0; bus.cpu_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_wb_mem_write", 256'(bus.mem_write), 256'd0);
      chk("rst_wb_mem_read",  256'(bus.mem_read),  256'd0);
      chk("rst_wb_hits",      256'(hit_count),     256'd0);
      chk("rst_wb_misses",    256'(miss_count),    256'd0);
      do_op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rdata, lat, nrd, nwr, rda, wba, wbd);
      chk("post_rst_latency", 256'(lat),   256'd4);
      chk("post_rst_nwrite",  256'(nwr),   256'd0);
      chk("post_rst_rdata",   256'(rdata), 256'h1000_0000);
      do_op(1'b1, 1'b0, 32'h440, 32'h0, 4'h0, rdata, lat, nrd, nwr, rda, wba, wbd);
      chk("post_rst_evict_nwrite", 256'(nwr), 256'd0);
      chk("post_rst_evict_nread",  256'(nrd), 256'd1);
      @(negedge clk);
      chk("post_rst_misses", 256'(miss_count), 256'd2);
      chk("post_rst_hits",   256'(hit_count),  256'd2);

      // Request held high with stray mem_resp: one IDLE gap between hits.
      hit0 = hit_count;
      bus.cpu_read = 1'b1; bus.cpu_addr = 32'h444; bus.mem_resp = 1'b1;
      pulses = 0; consec = 0; memseen = 0; prev_resp = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.cpu_resp) begin
            pulses++;
            if (prev_resp) consec++;
            if (bus.cpu_rdata != 32'h1004_0001) consec++;
         end
         if (bus.mem_read || bus.mem_write) memseen++;
         prev_resp = bus.cpu_resp;
      end
      bus.cpu_read = 1'b0; bus.mem_resp = 1'b0;
      @(negedge clk);
      chk("b2b_pulses",    256'(pulses),          256'd4);
      chk("b2b_gap_data",  256'(consec),          256'd0);
      chk("b2b_no_mem",    256'(memseen),         256'd0);
      chk("b2b_hits",      256'(hit_count - hit0), 256'd4);

      chk("rd_wr_overlap", 256'(overlap),   256'd0);
      chk("wb_before_rd",  256'(order_err), 256'd0);
      chk("addr_stable",   256'(unstable),  256'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
